// File: rtl/sync_frame_ctrl_if.sv
// Stream-side bundle for the frame controller.
// Carries the correlation metric stream, the detection threshold and the
// handshake signals observed on the synchronizer output.
interface sync_frame_ctrl_if;
  logic [31:0] i_corr_tdata;
  logic        i_corr_tvalid;
  logic [31:0] i_threshold;
  logic        i_sync_tvalid;
  logic        i_sync_tready;
  logic        i_sync_tlast;

  // Producer side: whoever supplies the metric stream and the monitor taps
  modport master (
    output i_corr_tdata,
    output i_corr_tvalid,
    output i_threshold,
    output i_sync_tvalid,
    output i_sync_tready,
    output i_sync_tlast
  );

  // Consumer side: the frame controller only observes these signals
  modport slave (
    input i_corr_tdata,
    input i_corr_tvalid,
    input i_threshold,
    input i_sync_tvalid,
    input i_sync_tready,
    input i_sync_tlast
  );
endinterface

// File: rtl/sync_frame_ctrl.sv
// Frame synchronisation controller.
// Arms on a software pulse, searches the correlation metric for a sample
// above threshold, tracks the peak until a window of G_PEAK_WIN valid
// samples brings no new maximum, then supervises the synchronizer output
// until the configured number of symbols (tlast beats) has gone by or the
// output stalls for G_TIMEOUT cycles.
module sync_frame_ctrl #(
  parameter int G_PEAK_WIN = 8,
  parameter int G_TIMEOUT  = 65536
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic        i_arm,
  input  logic        i_abort,
  input  logic [11:0] i_cfg_nfft,
  input  logic [11:0] i_cfg_cp_len,
  input  logic [3:0]  i_cfg_symbols,
  input  logic [9:0]  i_cfg_trig_offset,
  sync_frame_ctrl_if.slave bus,
  output logic [11:0] o_nfft,
  output logic [11:0] o_cp_len,
  output logic [3:0]  o_symbols,
  output logic [9:0]  o_trig_offset,
  output logic        o_max_sync,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout,
  output logic [1:0]  o_state,
  output logic [31:0] o_peak
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    PEAK   = 2'd2,
    STREAM = 2'd3
  } state_t;

  // Counter widths sized so the terminal value is representable
  localparam int WW = (G_PEAK_WIN < 2) ? 1 : $clog2(G_PEAK_WIN + 1);
  localparam int TW = (G_TIMEOUT  < 2) ? 1 : $clog2(G_TIMEOUT + 1);

  // Value held by a counter on the cycle before it would reach its limit
  localparam logic [WW-1:0] WIN_LAST = WW'(G_PEAK_WIN - 1);
  localparam logic [WW-1:0] WIN_MAX  = {WW{1'b1}};
  localparam logic [TW-1:0] TO_LAST  = TW'(G_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX   = {TW{1'b1}};

  state_t state_q, state_d;

  logic [11:0]   nfft_q,    nfft_d;
  logic [11:0]   cp_len_q,  cp_len_d;
  logic [3:0]    symbols_q, symbols_d;
  logic [9:0]    trig_q,    trig_d;

  logic [31:0]   peak_reg_q, peak_reg_d;
  logic [31:0]   peak_out_q, peak_out_d;
  logic [WW-1:0] win_cnt_q,  win_cnt_d;
  logic [3:0]    beat_cnt_q, beat_cnt_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;

  logic          max_sync_q, max_sync_d;
  logic          done_q,     done_d;
  logic          timeout_q,  timeout_d;
  logic          busy_q,     busy_d;

  // Handshake qualifiers and completion target
  logic          corr_hit;
  logic          sync_hs;
  logic          sync_last;
  logic [3:0]    sym_target;
  logic          frame_complete;
  logic          stall_expired;

  assign corr_hit   = bus.i_corr_tvalid && (bus.i_corr_tdata > bus.i_threshold);
  assign sync_hs    = bus.i_sync_tvalid && bus.i_sync_tready;
  assign sync_last  = sync_hs && bus.i_sync_tlast;

  // A zero symbol count still means one frame's worth of tlast
  assign sym_target = (symbols_q == 4'd0) ? 4'd1 : symbols_q;

  assign frame_complete = sync_last &&
                          (({1'b0, beat_cnt_q} + 5'd1) >= {1'b0, sym_target});
  assign stall_expired  = !sync_hs && (idle_cnt_q == TO_LAST);

  // Next-state and datapath decisions; abort overrides everything else
  always_comb begin
    state_d    = state_q;
    nfft_d     = nfft_q;
    cp_len_d   = cp_len_q;
    symbols_d  = symbols_q;
    trig_d     = trig_q;
    peak_reg_d = peak_reg_q;
    peak_out_d = peak_out_q;
    win_cnt_d  = win_cnt_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    max_sync_d = 1'b0;
    done_d     = 1'b0;
    timeout_d  = 1'b0;

    if (i_abort) begin
      state_d    = IDLE;
      win_cnt_d  = '0;
      beat_cnt_d = '0;
      idle_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          win_cnt_d  = '0;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          if (i_arm) begin
            nfft_d    = i_cfg_nfft;
            cp_len_d  = i_cfg_cp_len;
            symbols_d = i_cfg_symbols;
            trig_d    = i_cfg_trig_offset;
            state_d   = SEARCH;
          end
        end

        SEARCH: begin
          if (corr_hit) begin
            peak_reg_d = bus.i_corr_tdata;
            win_cnt_d  = '0;
            state_d    = PEAK;
          end
        end

        PEAK: begin
          // Invalid cycles freeze the window; equal samples are not new maxima
          if (bus.i_corr_tvalid) begin
            if (bus.i_corr_tdata > peak_reg_q) begin
              peak_reg_d = bus.i_corr_tdata;
              win_cnt_d  = '0;
            end else if (win_cnt_q == WIN_LAST) begin
              max_sync_d = 1'b1;
              peak_out_d = peak_reg_q;
              win_cnt_d  = '0;
              beat_cnt_d = '0;
              idle_cnt_d = '0;
              state_d    = STREAM;
            end else if (win_cnt_q != WIN_MAX) begin
              win_cnt_d = win_cnt_q + 1'b1;
            end
          end
        end

        STREAM: begin
          // Completion is checked first so it wins over a coincident stall
          if (frame_complete) begin
            done_d     = 1'b1;
            beat_cnt_d = '0;
            idle_cnt_d = '0;
            state_d    = IDLE;
          end else if (stall_expired) begin
            timeout_d  = 1'b1;
            beat_cnt_d = '0;
            idle_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            if (sync_last && (beat_cnt_q != 4'hF)) begin
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
            if (sync_hs) begin
              idle_cnt_d = '0;
            end else if (idle_cnt_q != TO_MAX) begin
              idle_cnt_d = idle_cnt_q + 1'b1;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // Busy tracks the state being entered so it lines up with o_state
    busy_d = (state_d != IDLE);
  end

  // State register
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Configuration, counters, peak tracking and registered status outputs
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      nfft_q     <= '0;
      cp_len_q   <= '0;
      symbols_q  <= '0;
      trig_q     <= '0;
      peak_reg_q <= '0;
      peak_out_q <= '0;
      win_cnt_q  <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      max_sync_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      nfft_q     <= nfft_d;
      cp_len_q   <= cp_len_d;
      symbols_q  <= symbols_d;
      trig_q     <= trig_d;
      peak_reg_q <= peak_reg_d;
      peak_out_q <= peak_out_d;
      win_cnt_q  <= win_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      max_sync_q <= max_sync_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  assign o_nfft        = nfft_q;
  assign o_cp_len      = cp_len_q;
  assign o_symbols     = symbols_q;
  assign o_trig_offset = trig_q;
  assign o_max_sync    = max_sync_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;
  assign o_state       = state_q;
  assign o_peak        = peak_out_q;

endmodule

// File: tb/tb_sync_frame_ctrl.sv
// Directed bench for sync_frame_ctrl: a vector table for the peak search
// on a metric ramp, then hand-written sequences for streaming, timeout,
// plateau with gaps, abort and mid-frame reset.
module tb_sync_frame_ctrl;
  localparam int PW = 8;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rstn;
  logic        arm, abort;
  logic [11:0] cfg_nfft, cfg_cp;
  logic [3:0]  cfg_sym;
  logic [9:0]  cfg_trig;

  logic [11:0] o_nfft, o_cp_len;
  logic [3:0]  o_symbols;
  logic [9:0]  o_trig_offset;
  logic        o_max_sync, o_busy, o_done, o_timeout;
  logic [1:0]  o_state;
  logic [31:0] o_peak;

  int checks = 0;
  int errors = 0;

  sync_frame_ctrl_if bus ();

  sync_frame_ctrl #(.G_PEAK_WIN(PW), .G_TIMEOUT(TO)) dut (
    .axis_aclk        (clk),
    .axis_aresetn     (rstn),
    .i_arm            (arm),
    .i_abort          (abort),
    .i_cfg_nfft       (cfg_nfft),
    .i_cfg_cp_len     (cfg_cp),
    .i_cfg_symbols    (cfg_sym),
    .i_cfg_trig_offset(cfg_trig),
    .bus              (bus),
    .o_nfft           (o_nfft),
    .o_cp_len         (o_cp_len),
    .o_symbols        (o_symbols),
    .o_trig_offset    (o_trig_offset),
    .o_max_sync       (o_max_sync),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_timeout        (o_timeout),
    .o_state          (o_state),
    .o_peak           (o_peak)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        valid;
    logic [1:0]  st;
    logic        ms;
    logic [31:0] pk;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic [31:0] d, input logic v, input logic [1:0] st,
                         input logic ms, input logic [31:0] pk);
    vec_t r;
    r.data = d; r.valid = v; r.st = st; r.ms = ms; r.pk = pk;
    vq.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_cfg(input logic [11:0] n, input logic [11:0] c,
                         input logic [3:0] s, input logic [9:0] t);
    cfg_nfft = n; cfg_cp = c; cfg_sym = s; cfg_trig = t;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Feed a plateau of 150 with an optional invalid gap; returns the sample
  // index at which o_max_sync was seen, or -1 if it never came
  task automatic plateau(input int gap_after, input int gap_len, output int ncyc);
    ncyc = -1;
    for (int i = 1; i <= 60; i++) begin
      bus.i_corr_tdata  = 32'd150;
      bus.i_corr_tvalid = !((i > gap_after) && (i <= gap_after + gap_len));
      tick();
      if (o_max_sync) begin
        ncyc = i;
        break;
      end
    end
    bus.i_corr_tvalid = 1'b0;
  endtask

  initial begin
    int n, tk, tcnt, dcnt, mcnt;

    rstn = 1'b0; arm = 1'b0; abort = 1'b0;
    cfg_nfft = '0; cfg_cp = '0; cfg_sym = '0; cfg_trig = '0;
    bus.i_corr_tdata = '0; bus.i_corr_tvalid = 1'b0; bus.i_threshold = 32'd100;
    bus.i_sync_tvalid = 1'b0; bus.i_sync_tready = 1'b0; bus.i_sync_tlast = 1'b0;

    // Ramp 0..200..0 in steps of 20; 100 sits exactly on the threshold
    for (int v = 0; v <= 100; v += 20) add_vec(v, 1'b1, 2'd1, 1'b0, 32'd0);
    for (int v = 120; v <= 200; v += 20) add_vec(v, 1'b1, 2'd2, 1'b0, 32'd0);
    for (int v = 180; v >= 60; v -= 20) add_vec(v, 1'b1, 2'd2, 1'b0, 32'd0);
    add_vec(32'd40, 1'b1, 2'd3, 1'b1, 32'd200);
    add_vec(32'd20, 1'b1, 2'd3, 1'b0, 32'd200);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", o_state, 0);
    check("rst_busy", o_busy, 0);
    check("rst_nfft", o_nfft, 0);
    check("rst_peak", o_peak, 0);
    check("rst_pulses", {o_done, o_timeout, o_max_sync}, 0);
    rstn = 1'b1;
    tick();

    // Arm and run the ramp table
    arm_cfg(12'd7, 12'd3, 4'd9, 10'h040);
    check("arm_state", o_state, 1);
    check("arm_busy", o_busy, 1);
    check("arm_cfg", {o_nfft, o_cp_len, o_symbols, o_trig_offset}, {12'd7, 12'd3, 4'd9, 10'h040});
    foreach (vq[i]) begin
      bus.i_corr_tdata  = vq[i].data;
      bus.i_corr_tvalid = vq[i].valid;
      tick();
      check($sformatf("ramp[%0d]_state", i), o_state, vq[i].st);
      check($sformatf("ramp[%0d]_maxsync", i), o_max_sync, vq[i].ms);
      check($sformatf("ramp[%0d]_peak", i), o_peak, vq[i].pk);
      check($sformatf("ramp[%0d]_busy", i), o_busy, (vq[i].st != 2'd0));
    end
    bus.i_corr_tvalid = 1'b0;

    // Nine tlast beats with tready held high
    bus.i_sync_tvalid = 1'b1; bus.i_sync_tready = 1'b1; bus.i_sync_tlast = 1'b1;
    for (int b = 1; b <= 9; b++) begin
      tick();
      check($sformatf("beat%0d_done", b), o_done, (b == 9));
      check($sformatf("beat%0d_state", b), o_state, (b == 9) ? 0 : 3);
    end
    bus.i_sync_tvalid = 1'b0; bus.i_sync_tready = 1'b0; bus.i_sync_tlast = 1'b0;
    check("done_busy", o_busy, 0);
    check("done_cfg", {o_nfft, o_cp_len, o_symbols, o_trig_offset}, {12'd7, 12'd3, 4'd9, 10'h040});
    tick();
    check("done_pulse_end", o_done, 0);

    // Plateau without gaps, then stall the output into a timeout
    arm_cfg(12'd7, 12'd3, 4'd9, 10'h040);
    plateau(0, 0, n);
    check("plateau_len", n, PW + 1);
    check("plateau_peak", o_peak, 150);
    check("plateau_state", o_state, 3);
    bus.i_sync_tvalid = 1'b1; bus.i_sync_tready = 1'b0;
    tk = -1; tcnt = 0; dcnt = 0;
    for (int k = 1; k <= TO + 5; k++) begin
      tick();
      if (o_timeout) begin tcnt++; tk = k; end
      if (o_done) dcnt++;
    end
    bus.i_sync_tvalid = 1'b0;
    check("timeout_cycle", tk, TO);
    check("timeout_count", tcnt, 1);
    check("timeout_nodone", dcnt, 0);
    check("timeout_state", o_state, 0);

    // Plateau with a 3-cycle gap: closure delayed by 3
    arm_cfg(12'd7, 12'd3, 4'd9, 10'h040);
    plateau(2, 3, n);
    check("gap_len", n, PW + 1 + 3);
    check("gap_peak", o_peak, 150);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_stream_state", o_state, 0);
    check("abort_stream_pulses", {o_done, o_timeout, o_max_sync}, 0);

    // Abort in PEAK; an arm during PEAK is ignored
    arm_cfg(12'd100, 12'd20, 4'd5, 10'h155);
    bus.i_corr_tdata = 32'd150; bus.i_corr_tvalid = 1'b1;
    tick();
    check("peak_entry_state", o_state, 2);
    arm_cfg(12'd1, 12'd2, 4'd3, 10'd4);
    check("arm_in_peak_ignored", o_nfft, 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_peak_state", o_state, 0);
    check("abort_peak_cfg", {o_nfft, o_symbols, o_trig_offset}, {12'd100, 4'd5, 10'h155});
    mcnt = 0;
    for (int k = 0; k < PW + 2; k++) begin
      tick();
      if (o_max_sync || o_state != 2'd0) mcnt++;
    end
    check("abort_peak_quiet", mcnt, 0);
    bus.i_corr_tvalid = 1'b0;

    // Abort and arm together in IDLE
    cfg_nfft = 12'd1; cfg_cp = 12'd2; cfg_sym = 4'd3; cfg_trig = 10'd4;
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    check("arm_abort_state", o_state, 0);
    check("arm_abort_busy", o_busy, 0);
    check("arm_abort_cfg", o_nfft, 100);

    // Reset mid-STREAM, then symbols=0 finishes after one tlast
    arm_cfg(12'd7, 12'd3, 4'd9, 10'h040);
    plateau(0, 0, n);
    check("pre_rst_state", o_state, 3);
    rstn = 1'b0;
    #1;
    check("rst_mid_state", o_state, 0);
    check("rst_mid_outs", {o_nfft, o_cp_len, o_symbols, o_trig_offset, o_busy}, 0);
    check("rst_mid_peak", o_peak, 0);
    check("rst_mid_pulses", {o_done, o_timeout, o_max_sync}, 0);
    repeat (3) tick();
    rstn = 1'b1;
    bus.i_corr_tdata = 32'd150; bus.i_corr_tvalid = 1'b1;
    repeat (3) tick();
    bus.i_corr_tvalid = 1'b0;
    check("rst_needs_arm", o_state, 0);
    arm_cfg(12'd7, 12'd3, 4'd0, 10'h040);
    plateau(0, 0, n);
    check("sym0_plateau", n, PW + 1);
    bus.i_sync_tvalid = 1'b1; bus.i_sync_tready = 1'b1; bus.i_sync_tlast = 1'b1;
    tick();
    bus.i_sync_tvalid = 1'b0; bus.i_sync_tready = 1'b0; bus.i_sync_tlast = 1'b0;
    check("sym0_done", o_done, 1);
    check("sym0_state", o_state, 0);
    tick();
    check("sym0_done_end", o_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_frame_ctrl.md
SYNC_FRAME_CTRL -- requirements
Module: sync_frame_ctrl

Interface
REQ-001 The block SHALL have parameter G_PEAK_WIN, default 8, meaning the number of consecutive valid correlation samples with no new maximum that closes a peak window.
REQ-002 The block SHALL have parameter G_TIMEOUT, default 65536, meaning the idle cycles allowed in STREAM without an output handshake before abort.
REQ-003 The block SHALL have port axis_aclk, input, 1 bit: sole clock.
REQ-004 The block SHALL have port axis_aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the following input ports: i_arm (1): arm pulse; i_abort (1): abort pulse; i_cfg_nfft (12), i_cfg_cp_len (12), i_cfg_symbols (4), i_cfg_trig_offset (10): software configuration.
REQ-006 The block SHALL have the following input ports: i_corr_tdata (32): unsigned correlation metric; i_corr_tvalid (1); i_threshold (32): unsigned detection threshold.
REQ-007 The block SHALL have the following input ports for monitoring the synchronizer output: i_sync_tvalid, i_sync_tready, i_sync_tlast (1 each).
REQ-008 The block SHALL have the following output ports driving the synchronizer: o_nfft (12), o_cp_len (12), o_symbols (4), o_trig_offset (10), o_max_sync (1).
REQ-009 The block SHALL have the following status outputs: o_busy (1), o_done (1, pulse), o_timeout (1, pulse), o_state (2), o_peak (32): the largest metric in the last peak window.

Function
REQ-010 The block SHALL implement states IDLE=0, SEARCH=1, PEAK=2 and STREAM=3, with o_state equal to the current state encoding.
REQ-011 In IDLE, i_arm=1 SHALL latch all i_cfg_* values into o_* and transition to SEARCH on the next edge; i_arm in any other state SHALL be ignored.
REQ-012 o_* configuration outputs SHALL change only on an accepted arm and SHALL hold their values through SEARCH, PEAK, STREAM and the return to IDLE.
REQ-013 In SEARCH, a sample with i_corr_tvalid=1 and i_corr_tdata > i_threshold (strict compare) SHALL load the peak register with that sample, clear the window counter, and move to PEAK.
REQ-014 In PEAK, for each valid sample: if the sample is strictly greater than the peak register, the peak register SHALL be updated and the window counter cleared; otherwise the window counter SHALL increment. A sample equal to the peak SHALL count as not new.
REQ-015 When the window counter reaches G_PEAK_WIN, o_max_sync SHALL be 1 for exactly one cycle, o_peak SHALL take the peak register value on that same edge, and the state SHALL become STREAM.
REQ-016 Cycles with i_corr_tvalid=0 in PEAK SHALL leave both the counter and the peak register unchanged.
REQ-017 In STREAM, the block SHALL count beats where i_sync_tvalid & i_sync_tready & i_sync_tlast are all 1; when the count reaches max(o_symbols,1), o_done SHALL pulse for one cycle and the state SHALL become IDLE on the same edge.
REQ-018 In STREAM, the idle counter SHALL clear on any i_sync_tvalid & i_sync_tready beat and otherwise increment; on reaching G_TIMEOUT it SHALL pulse o_timeout for one cycle and go to IDLE.
REQ-019 i_abort=1 SHALL force IDLE on the next edge from any state, clear all counters, and produce no o_done, o_timeout or o_max_sync pulse; i_abort SHALL take priority over i_arm and every other transition.
REQ-020 If the completion condition and the timeout condition occur in the same cycle, completion SHALL win: o_done pulses and o_timeout stays 0.
REQ-021 o_busy SHALL equal (state != IDLE) and SHALL be registered.
REQ-022 All outputs SHALL be registered, and counters SHALL saturate rather than wrap.

Reset
REQ-023 While axis_aresetn=0, the following SHALL hold asynchronously: state=IDLE, o_nfft=0, o_cp_len=0, o_symbols=0, o_trig_offset=0, o_max_sync=0, o_busy=0, o_done=0, o_timeout=0, o_peak=0, and all counters=0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame without a pulse; after release, the block SHALL require a new i_arm.

Verification
REQ-025 Arm with nfft=7, cp_len=3, symbols=9, trig_offset=0x040; threshold=100; metric ramp 0..200..0 peaking at 200 -> single o_max_sync pulse exactly G_PEAK_WIN valid samples after 200 arrives, with o_peak=200 and o_state=3.
REQ-026 In STREAM with symbols=9 and tready held 1, drive 9 tlast beats -> o_done pulses on the 9th beat, o_busy=0 on the next cycle, and o_* still reads 7/3/9/0x040.
REQ-027 In STREAM with tready=0 for G_TIMEOUT cycles -> o_timeout pulses once, state=IDLE, no o_done.
REQ-028 Metric plateau of repeated 150 with threshold=100 -> window closes after G_PEAK_WIN samples with o_peak=150; insert tvalid=0 gaps -> closure is delayed by the gap length only.
REQ-029 i_abort in PEAK, and separately i_abort and i_arm together in IDLE -> IDLE, no o_max_sync, config unchanged for the abort-in-PEAK case.
REQ-030 axis_aresetn low for 3 cycles during STREAM -> all outputs 0 immediately; new arm with symbols=0 -> done after 1 tlast beat.
